// File: rtl/com_uart_rx_sample_timer.sv
// com_uart_rx_sample_timer: oversampled UART receive timer with start validation, 3-sample majority voting and per-bit strobes
module com_uart_rx_sample_timer #(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1,
    parameter int IDX_WIDTH  = $clog2(DATA_BITS + PARITY_EN + STOP_BITS)
) (
    input  logic                 normal_mode_clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx_port,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 stop_cond,
    output logic                 sample_valid,
    output logic                 sample_bit,
    output logic [IDX_WIDTH-1:0] bit_index,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 start_err,
    output logic                 stop_err,
    output logic                 cfg_err
);
    localparam int M = OVERSAMPLE / 2;
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_DATA = IDX_WIDTH'(DATA_BITS + PARITY_EN - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_STOP = IDX_WIDTH'(DATA_BITS + PARITY_EN + STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q;
    logic                 rx_meta_q, rx_s_q, rx_d_q, v0_q, v1_q;
    logic                 sample_valid_q, sample_bit_q, frame_done_q, start_err_q, stop_err_q, cfg_err_q;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d, div_lat_q;
    logic [OSW-1:0]       os_cnt_q, os_cnt_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d, bit_index_q;
    logic                 tick, at_v0, at_v1, at_vote, at_end, maj, start_ok;

    always_comb begin
        tick      = state_q != IDLE && div_cnt_q == div_lat_q - DIV_WIDTH'(1);
        at_v0     = tick && os_cnt_q == OSW'(M - 1);
        at_v1     = tick && os_cnt_q == OSW'(M);
        at_vote   = tick && os_cnt_q == OSW'(M + 1);
        at_end    = tick && os_cnt_q == OS_LAST;
        maj       = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
        os_cnt_d  = at_end ? '0 : os_cnt_q + OSW'(tick);
        idx_d     = idx_q + IDX_WIDTH'(at_end);
        start_ok  = rx_en && div_value != '0 && rx_d_q && !rx_s_q;
    end

    // Later assignments win: a vote that ends the frame overrides the end-of-bit transition.
    always_ff @(posedge normal_mode_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            rx_d_q         <= 1'b1;
            v0_q           <= 1'b0;
            v1_q           <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_bit_q   <= 1'b0;
            frame_done_q   <= 1'b0;
            start_err_q    <= 1'b0;
            stop_err_q     <= 1'b0;
            cfg_err_q      <= 1'b0;
            div_cnt_q      <= '0;
            div_lat_q      <= '0;
            os_cnt_q       <= '0;
            idx_q          <= '0;
            bit_index_q    <= '0;
        end else begin
            {rx_meta_q, rx_s_q, rx_d_q} <= {rx_port, rx_meta_q, rx_s_q};
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            start_err_q    <= 1'b0;
            stop_err_q     <= 1'b0;
            cfg_err_q      <= div_value == '0;
            if (stop_cond) begin
                state_q <= IDLE;
            end else if (state_q == IDLE) begin
                if (start_ok) begin
                    state_q     <= START;
                    div_cnt_q   <= '0;
                    os_cnt_q    <= '0;
                    idx_q       <= '0;
                    bit_index_q <= '0;
                    div_lat_q   <= div_value;
                end
            end else begin
                div_cnt_q <= div_cnt_d;
                os_cnt_q  <= os_cnt_d;
                if (at_v0) v0_q <= rx_s_q;
                if (at_v1) v1_q <= rx_s_q;
                if (state_q != START) idx_q <= idx_d;
                if (at_end && state_q == START) state_q <= DATA;
                if (at_end && state_q == DATA && idx_q == LAST_DATA) state_q <= STOP;
                if (at_vote) begin
                    if (state_q == START) begin
                        start_err_q <= maj;
                        if (maj) state_q <= IDLE;
                    end else begin
                        sample_valid_q <= 1'b1;
                        sample_bit_q   <= maj;
                        bit_index_q    <= idx_q;
                        stop_err_q     <= state_q == STOP && !maj;
                        if (state_q == STOP && idx_q == LAST_STOP) begin
                            frame_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                end
            end
        end
    end

    assign sample_valid = sample_valid_q;
    assign sample_bit   = sample_bit_q;
    assign bit_index    = bit_index_q;
    assign frame_busy   = state_q != IDLE;
    assign frame_done   = frame_done_q;
    assign start_err    = start_err_q;
    assign stop_err     = stop_err_q;
    assign cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_com_uart_rx_sample_timer.sv
// tb_com_uart_rx_sample_timer: directed frames with a strobe scoreboard for com_uart_rx_sample_timer
module tb_com_uart_rx_sample_timer;
    logic        clk = 1'b0;
    logic        rst_n, rx_en, rx_port, stop_cond;
    logic [15:0] div_value;
    logic        sample_valid, sample_bit, frame_busy, frame_done, start_err, stop_err, cfg_err;
    logic [3:0]  bit_index;

    typedef struct {
        int   idx;
        logic b;
        logic se;
        logic fd;
        int   gap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_start = 0;
    int   n_stop = 0;
    int   n_done = 0;

    com_uart_rx_sample_timer dut (
        .normal_mode_clk(clk),
        .rst_n(rst_n),
        .rx_en(rx_en),
        .rx_port(rx_port),
        .div_value(div_value),
        .stop_cond(stop_cond),
        .sample_valid(sample_valid),
        .sample_bit(sample_bit),
        .bit_index(bit_index),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .start_err(start_err),
        .stop_err(stop_err),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected strobes: n entries, data LSB-first then the stop bit at index 8.
    task automatic push_frame(input logic [7:0] d, input logic stopv, input int n, input int gap);
        for (int i = 0; i < n; i++)
            q.push_back('{idx: i, b: (i < 8) ? d[i] : stopv, se: (i == 8) && !stopv, fd: i == 8,
                          gap: (i == 0) ? 0 : gap});
    endtask

    // With div=2 the middle vote of a bit sees the line value held across bit-start edge + 18.
    task automatic send_frame(input logic [7:0] d, input logic stopv, input int cpb, input int glitch_bit);
        logic v;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : (i == 9) ? stopv : d[i-1];
            rx_port = v;
            if (i - 1 == glitch_bit) begin
                repeat (18) @(negedge clk);
                rx_port = ~v;
                @(negedge clk);
                rx_port = v;
                repeat (cpb - 19) @(negedge clk);
            end else begin
                repeat (cpb) @(negedge clk);
            end
        end
        rx_port = 1'b1;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max && q.size() != 0; i++) @(negedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (start_err) n_start++;
            if (stop_err) n_stop++;
            if (frame_done) n_done++;
        end
        if (sample_valid) begin
            check("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("bit_index", bit_index, e.idx);
                check("sample_bit", sample_bit, e.b);
                check("stop_err", stop_err, e.se);
                check("frame_done", frame_done, e.fd);
                if (e.gap != 0) check("strobe_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rx_en = 1'b1;
        rx_port = 1'b1;
        stop_cond = 1'b0;
        div_value = 16'd2;
        repeat (5) @(negedge clk);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sample_bit", sample_bit, 0);
        check("rst_bit_index", bit_index, 0);
        check("rst_frame_busy", frame_busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_start_err", start_err, 0);
        check("rst_stop_err", stop_err, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        push_frame(8'hA5, 1'b1, 9, 32);
        send_frame(8'hA5, 1'b1, 32, -1);
        wait_drain(200);
        check("t1_done", n_done, 1);
        check("t1_stop_err", n_stop, 0);
        check("t1_start_err", n_start, 0);
        check("t1_idle", frame_busy, 0);

        rx_port = 1'b0;
        repeat (10) @(negedge clk);
        rx_port = 1'b1;
        repeat (60) @(negedge clk);
        check("t2_start_err", n_start, 1);
        check("t2_idle", frame_busy, 0);
        check("t2_done", n_done, 1);

        push_frame(8'h3C, 1'b0, 9, 32);
        send_frame(8'h3C, 1'b0, 32, -1);
        wait_drain(200);
        check("t3_stop_err", n_stop, 1);
        check("t3_done", n_done, 2);

        push_frame(8'h5A, 1'b1, 9, 32);
        send_frame(8'h5A, 1'b1, 32, 2);
        wait_drain(200);
        check("t4_done", n_done, 3);

        push_frame(8'hF3, 1'b1, 4, 32);
        fork
            send_frame(8'hF3, 1'b1, 32, -1);
            begin
                repeat (32 * 5 + 5) @(negedge clk);
                stop_cond = 1'b1;
                @(negedge clk);
                stop_cond = 1'b0;
                @(negedge clk);
                check("t5_busy_low", frame_busy, 0);
            end
        join
        wait_drain(200);
        check("t5_no_done", n_done, 3);
        push_frame(8'h55, 1'b1, 9, 32);
        send_frame(8'h55, 1'b1, 32, -1);
        wait_drain(200);
        check("t5_next_done", n_done, 4);
        check("t5_start_err", n_start, 1);

        push_frame(8'hA5, 1'b1, 9, 32);
        fork
            send_frame(8'hA5, 1'b1, 32, -1);
            begin
                repeat (100) @(negedge clk);
                div_value = 16'd4;
            end
        join
        wait_drain(200);
        push_frame(8'hC3, 1'b1, 9, 64);
        send_frame(8'hC3, 1'b1, 64, -1);
        wait_drain(400);
        check("t6_done", n_done, 6);
        div_value = 16'd0;
        repeat (3) @(negedge clk);
        check("t6_cfg_err", cfg_err, 1);
        fork
            send_frame(8'h00, 1'b1, 64, -1);
            begin
                repeat (50) @(negedge clk);
                check("t6_ignored", frame_busy, 0);
            end
        join
        check("t6_no_start_err", n_start, 1);
        check("t6_no_done", n_done, 6);
        div_value = 16'd2;
        repeat (3) @(negedge clk);
        check("t6_cfg_clear", cfg_err, 0);
        check("final_stop_err", n_stop, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/com_uart_rx_sample_timer.md
Name: com_uart_rx_sample_timer

Overview:
Parametrised, fully synchronous successor to the UART receive baud timer. All logic runs on one clock with clock enables; there are no gated or derived clocks. It provides:
- a runtime-programmable divisor and an oversampling tick;
- falling-edge start detection with mid-bit start validation;
- 3-sample majority voting per bit;
- per-bit sample strobes with index, plus framing/start error flags.

It sits between the rx pin and the rx shift/controller logic.

Parameters:
DIV_WIDTH, 16, width of runtime divisor input
OVERSAMPLE, 16, oversample ticks per bit; even, >=4
DATA_BITS, 8, data bits per frame (5..9)
PARITY_EN, 0, 1 = one parity bit after data
STOP_BITS, 1, stop bits (1 or 2)
IDX_WIDTH, $clog2(DATA_BITS+PARITY_EN+STOP_BITS), width of bit_index

Ports:
normal_mode_clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
rx_en  in  1  receiver enable; when low, no new frame is started
rx_port  in  1  asynchronous serial input, idle high
div_value  in  DIV_WIDTH  clock cycles per oversample tick
stop_cond  in  1  abort from rx controller; forces IDLE
sample_valid  out  1  one-cycle strobe: sample_bit/bit_index valid
sample_bit  out  1  majority-voted bit value
bit_index  out  IDX_WIDTH  0..DATA_BITS-1 data, then parity (if enabled), then stop bit(s)
frame_busy  out  1  high in START/DATA/STOP states
frame_done  out  1  one-cycle pulse at final stop-bit sample
start_err  out  1  one-cycle pulse when the start bit is rejected
stop_err  out  1  one-cycle pulse when any stop sample reads 0
cfg_err  out  1  level, high while div_value == 0

Behaviour:
Reset and input sync:
- rst_n low: state IDLE; all outputs 0; internal counters 0.
- rx_port passes through a 2-FF synchroniser (rx_s); sync flops reset to 1. rx_d is rx_s delayed one cycle.

Tick generation:
- div_cnt runs 0..div_lat-1. tick asserts on the cycle div_cnt == div_lat-1, and div_cnt wraps to 0.
- div_lat is latched from div_value on frame start. div_value changes mid-frame have no effect until the next frame.
- os_cnt runs 0..OVERSAMPLE-1 and advances on each tick.
- Define M = OVERSAMPLE/2. Votes are taken on the ticks where os_cnt = M-1, M and M+1.
- On the M+1 tick, bit = majority of the three votes.
- Registered results appear the next cycle: sample_valid, sample_bit, bit_index, and any error/done pulse.

State machine:
- IDLE: if rx_en && div_value != 0 && rx_d == 1 && rx_s == 0, then:
  - next cycle enter START;
  - div_cnt = 0, os_cnt = 0, bit_index = 0;
  - latch div_lat.
- IDLE with div_value == 0: edges are ignored; cfg_err is high.
- START: at the vote, majority 1 gives a start_err pulse and returns to IDLE (no sample_valid). Majority 0 continues; on the os_cnt == OVERSAMPLE-1 tick, enter DATA with os_cnt = 0.
- DATA: at each vote, pulse sample_valid with the current bit_index. At end of bit (os_cnt == OVERSAMPLE-1 tick), increment bit_index. After bit index DATA_BITS+PARITY_EN-1 completes, enter STOP.
- STOP: at each vote, pulse sample_valid. A 0 vote also pulses stop_err in the same cycle as sample_valid.
  - Last stop bit: at its vote, pulse frame_done (same cycle as sample_valid) and go to IDLE without waiting for the bit end. This allows a start edge half a bit later to be detected.
  - STOP_BITS = 2: the first stop bit completes its full period before the second begins.
- Precedence (highest first): reset > stop_cond > normal operation.
  - stop_cond high in any state forces IDLE next cycle with no pulses.
  - rx_en low mid-frame does not abort the frame.
- frame_busy is combinational from state (not IDLE).
- bit_index holds its last value in IDLE.
- div_value == 1 is legal: tick every cycle.

Test Plan:
1. div_value=2, OVERSAMPLE=16 (32 cycles/bit); send 0xA5 LSB-first, 1 stop -> 9 sample_valid strobes, each 32 cycles apart. Indices 0..8, bits 1,0,1,0,0,1,0,1 then 1. frame_done coincides with index 8; no errors.
2. Glitch: rx_port low for 10 cycles, then high, div=2 -> start_err pulses once; state back to IDLE; no sample_valid.
3. Framing error: 0x3C with stop bit driven 0 -> stop_err and frame_done both pulse on the index-8 strobe.
4. Single-cycle 1-glitch placed on the middle vote of data bit 2 (value 0) -> sample_bit for index 2 is 0 (majority).
5. stop_cond asserted during data bit 4 -> frame_busy low within 2 cycles; no further strobes. A following frame 0x55 is received correctly.
6. Reconfig: div_value changed 2->4 mid-frame -> current frame timing unchanged. Next frame has 64 cycles/bit. div_value=0 -> cfg_err=1 and falling edges are ignored.
